// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the en/ready handshake with the
// 128x8 memory and presents each fetched byte to the decoder via valid/ack.
module fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DATA_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(33),
  parameter int                 TIMEOUT  = 15,
  parameter logic [3:0]         HALT_OP  = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic              fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_GAP,
    S_REQ,
    S_HOLD,
    S_HALTED
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                mem_en_q, mem_en_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic                halted_q, halted_d;
  logic                fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    wait_inc;

  assign wait_inc = wait_cnt_q + 1'b1;

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a signal unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    mem_en_d      = mem_en_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    fetch_err_d   = fetch_err_q;
    wait_cnt_d    = wait_cnt_q;

    if (redirect) begin
      // Redirect wins over everything, including a same-cycle ready or ack.
      pc_d          = redirect_addr;
      instr_valid_d = 1'b0;
      mem_en_d      = 1'b0;
      halted_d      = 1'b0;
      wait_cnt_d    = '0;
      state_d       = S_GAP;
    end else begin
      unique case (state_q)
        S_GAP: begin
          mem_en_d = 1'b1;
          state_d  = S_REQ;
        end
        S_REQ: begin
          if (mem_ready) begin
            instr_d       = mem_data;
            instr_pc_d    = pc_q;
            pc_d          = pc_q + 1'b1;
            instr_valid_d = 1'b1;
            mem_en_d      = 1'b0;
            wait_cnt_d    = '0;
            state_d       = S_HOLD;
          end else begin
            wait_cnt_d = wait_inc;
            if (wait_inc == CNT_W'(TIMEOUT)) begin
              fetch_err_d = 1'b1;
              halted_d    = 1'b1;
              mem_en_d    = 1'b0;
              state_d     = S_HALTED;
            end
          end
        end
        S_HOLD: begin
          // en is already low here, so the memory's count clears without a GAP.
          if (instr_ack) begin
            instr_valid_d = 1'b0;
            if (instr_q[DATA_W-1 -: 4] == HALT_OP) begin
              halted_d = 1'b1;
              state_d  = S_HALTED;
            end else begin
              mem_en_d = 1'b1;
              state_d  = S_REQ;
            end
          end
        end
        S_HALTED: begin
          mem_en_d      = 1'b0;
          instr_valid_d = 1'b0;
        end
        default: state_d = S_GAP;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_GAP;
      pc_q          <= RESET_PC;
      mem_en_q      <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_err_q   <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_en_q      <= mem_en_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fetch_err_q   <= fetch_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_read    = mem_en_q;
  assign mem_write   = 1'b0;
  assign mem_address = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a 128x8 memory model with a 2-cycle ready, plus a
// PC-stream reference model predicting each delivered instruction.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_en, mem_read, mem_write;
  logic [7:0] mem_address, mem_data;
  logic       mem_ready;
  logic [7:0] instr, instr_pc;
  logic       instr_valid;
  logic       instr_ack = 1'b1;
  logic       redirect = 1'b0;
  logic [7:0] redirect_addr = 8'd0;
  logic       halted, fetch_err;

  logic [7:0] ram [128];
  int         mcnt = 0;
  logic       mrdy = 1'b0;
  logic [7:0] mdata = 8'd0;
  logic       stall = 1'b0;

  int tests = 0;
  int fails = 0;
  int model_pc;
  int n;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_data(mem_data), .mem_ready(mem_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ack(instr_ack), .redirect(redirect), .redirect_addr(redirect_addr),
    .halted(halted), .fetch_err(fetch_err)
  );

  // Memory: count restarts whenever en is low; ready pulses two edges after en rises.
  always @(posedge clk) begin
    if (!mem_en) begin
      mcnt <= 0;
      mrdy <= 1'b0;
    end else begin
      mcnt  <= mcnt + 1;
      mrdy  <= (mcnt == 1);
      mdata <= ram[mem_address[6:0]];
    end
  end
  assign mem_data  = mdata;
  assign mem_ready = mrdy & ~stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!instr_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    if (cyc == 20) check("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic expect_fetch(input string tag);
    check({tag, "_instr"}, {24'd0, instr}, {24'd0, ram[model_pc % 128]});
    check({tag, "_pc"}, {24'd0, instr_pc}, model_pc);
    model_pc = (model_pc + 1) % 256;
  endtask

  task automatic do_redirect(input int addr);
    redirect      = 1'b1;
    redirect_addr = addr[7:0];
    tick();
    redirect      = 1'b0;
    model_pc      = addr;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = 8'($urandom_range(0, 8'hEF));
    ram[33] = 8'hDC;
    ram[34] = 8'hC1;
    ram[40] = 8'hF0;
    ram[57] = 8'h8C;

    // Reset values
    tick(); tick();
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", {24'd0, instr}, 32'd0);
    check("rst_instr_pc", {24'd0, instr_pc}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);

    // First two fetches with ack tied high
    model_pc = 33;
    rst_n = 1'b1;
    n = 0;
    while (!mem_en && n < 5) begin tick(); n++; end
    check("first_req_delay", n, 32'd1);
    check("first_addr", {24'd0, mem_address}, 32'd33);
    check("mem_read_mirror", {31'd0, mem_read}, 32'd1);
    n = 0;
    while (!instr_valid && n < 10) begin tick(); n++; end
    check("first_latency", n, 32'd3);
    expect_fetch("first");
    tick();
    check("valid_pulse", {31'd0, instr_valid}, 32'd0);
    check("second_req", {23'd0, mem_en, mem_address}, {23'd0, 1'b1, 8'd34});
    wait_valid(n);
    check("second_latency", n, 32'd3);
    expect_fetch("second");

    // Decoder stalls: instruction held, memory idle
    instr_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_stable", {15'd0, instr_valid, instr, instr_pc, mem_en},
            {15'd0, 1'b1, 8'hC1, 8'd34, 1'b0});
    end
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    check("ack_resume", {22'd0, instr_valid, mem_en, mem_address},
          {22'd0, 1'b0, 1'b1, 8'(model_pc)});

    // Redirect during REQ (random point, possibly coinciding with ready)
    repeat ($urandom_range(0, 2)) tick();
    check("in_req", {31'd0, mem_en}, 32'd1);
    do_redirect(57);
    check("redir_drop", {30'd0, mem_en, instr_valid}, 32'd0);
    tick();
    check("redir_gap_one", {23'd0, mem_en, mem_address}, {23'd0, 1'b1, 8'd57});
    wait_valid(n);
    check("redir_latency", n, 32'd3);
    expect_fetch("redir57");

    // Random ack delays over a run of sequential fetches
    do_redirect(64 + $urandom_range(0, 20));
    for (int k = 0; k < 8; k++) begin
      int d;
      wait_valid(n);
      expect_fetch("rand");
      d = $urandom_range(0, 3);
      for (int j = 0; j < d; j++) begin
        tick();
        check("rand_hold", {23'd0, instr_valid, instr_pc}, {23'd0, 1'b1, 8'((model_pc + 255) % 256)});
      end
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
      check("rand_ack", {31'd0, instr_valid}, 32'd0);
    end

    // PC wraps from 255 to 0
    do_redirect(255);
    wait_valid(n);
    expect_fetch("wrap255");
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    check("wrap_addr", {23'd0, mem_en, mem_address}, {23'd0, 1'b1, 8'd0});
    wait_valid(n);
    expect_fetch("wrap0");

    // HALT opcode acked in the same cycle as a redirect is not acted on
    do_redirect(40);
    wait_valid(n);
    expect_fetch("halt_op");
    redirect = 1'b1; redirect_addr = 8'd64; instr_ack = 1'b1;
    tick();
    redirect = 1'b0; instr_ack = 1'b0; model_pc = 64;
    check("discard_halt", {29'd0, halted, instr_valid, mem_en}, 32'd0);
    wait_valid(n);
    expect_fetch("after_discard");
    check("no_halt", {31'd0, halted}, 32'd0);

    // HALT stops fetching until redirect
    do_redirect(40);
    wait_valid(n);
    expect_fetch("halt2");
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    check("halted_set", {29'd0, halted, instr_valid, mem_en}, {29'd0, 3'b100});
    for (int i = 0; i < 20; i++) begin
      tick();
      check("halted_idle", {30'd0, halted, mem_en}, {30'd0, 2'b10});
    end
    do_redirect(33);
    check("resume_halted", {31'd0, halted}, 32'd0);
    wait_valid(n);
    expect_fetch("resume");

    // Ready timeout, sticky error, then async reset mid-REQ
    stall = 1'b1;
    do_redirect(70);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fetch_err) break;
      if (mem_en) n++;
    end
    check("timeout_cycles", n, 32'd15);
    check("timeout_flags", {29'd0, fetch_err, halted, mem_en}, {29'd0, 3'b110});
    do_redirect(70);
    check("err_sticky", {30'd0, fetch_err, halted}, {30'd0, 2'b10});
    tick();
    check("req_before_rst", {31'd0, mem_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {12'd0, mem_en, instr_valid, halted, fetch_err, instr, instr_pc}, 32'd0);
    tick();
    rst_n = 1'b1;
    stall = 1'b0;
    instr_ack = 1'b1;
    model_pc = 33;
    wait_valid(n);
    expect_fetch("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
